// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 master bridge: default widths, AXI burst and
// response encodings, and the bridge FSM state type.
package axi4_pkg;

  localparam int unsigned DEF_ID_W   = 4;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 64;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRdAr,
    StRdR,
    StWrAw,
    StWrB
  } bridge_state_e;

endpackage

// File: rtl/axi4_wr_channel.sv
// AW/W valid generation for the single-beat write. While active, awvalid and
// wvalid start together; each drops after its own handshake, and done_o fires
// in the cycle the second (or both) handshakes complete.
// Ports: aclk/areset (sync active-high), active_i (bridge in write-issue
// state), awready_i/wready_i from slave, awvalid_o/wvalid_o to slave, done_o.
module axi4_wr_channel (
  input  logic aclk,
  input  logic areset,
  input  logic active_i,
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic done_o
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic aw_seen, w_seen;

  always_comb begin
    awvalid_o = active_i && !aw_done_q;
    wvalid_o  = active_i && !w_done_q;
    aw_seen   = aw_done_q || (awvalid_o && awready_i);
    w_seen    = w_done_q || (wvalid_o && wready_i);
    done_o    = active_i && aw_seen && w_seen;
    // Flags clear as the write leaves issue so the next write starts fresh.
    aw_done_d = done_o ? 1'b0 : aw_seen;
    w_done_d  = done_o ? 1'b0 : w_seen;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/axi4_master_bridge.sv
// Bridge from a simple valid/ready request port to an AXI4 master. One request
// at a time: reads go out as an INCR burst with R beats passed straight through
// to the response port; writes go out as a single AW+W beat with the B
// response forwarded. AXI error responses and protocol mismatches set resp_err.
// Ports: aclk/areset (sync active-high); req_* request port; resp_* response
// port; ar*/r*/aw*/w*/b* AXI4 master channels.
module axi4_master_bridge
  import axi4_pkg::*;
#(
  parameter int unsigned ID_W   = DEF_ID_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_ID  = 0,
  parameter int unsigned WR_ID  = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  // Request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [7:0]            req_len,
  input  logic [2:0]            req_size,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  // Response port
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_last,
  output logic                  resp_err,
  // AR
  output logic [ADDR_W-1:0]     araddr,
  output logic [ID_W-1:0]       arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  // R
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AW
  output logic [ADDR_W-1:0]     awaddr,
  output logic [ID_W-1:0]       awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  // W
  output logic [ID_W-1:0]       wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // B
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam logic [ID_W-1:0] RdId = ID_W'(RD_ID);
  localparam logic [ID_W-1:0] WrId = ID_W'(WR_ID);

  bridge_state_e state_q, state_d;

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [7:0]          cnt_q, cnt_d;

  logic req_hs, r_hs, b_hs;
  logic cnt_at_len, rd_last;
  logic wr_active, wr_done;

  assign req_hs     = req_valid && req_ready;
  assign r_hs       = rvalid && rready;
  assign b_hs       = bvalid && bready;
  assign cnt_at_len = (cnt_q == len_q);
  // Burst ends on either the slave's rlast or our own beat count, whichever
  // comes first; a disagreement between them is reported as an error.
  assign rd_last    = rlast || cnt_at_len;
  assign wr_active  = (state_q == StWrAw);

  axi4_wr_channel u_wr_channel (
    .aclk      (aclk),
    .areset    (areset),
    .active_i  (wr_active),
    .awready_i (awready),
    .wready_i  (wready),
    .awvalid_o (awvalid),
    .wvalid_o  (wvalid),
    .done_o    (wr_done)
  );

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (req_hs) state_d = req_write ? StWrAw : StRdAr;
      StRdAr: if (arready) state_d = StRdR;
      StRdR:  if (r_hs && rd_last) state_d = StIdle;
      StWrAw: if (wr_done) state_d = StWrB;
      StWrB:  if (b_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == StIdle) && !areset;
    arvalid    = (state_q == StRdAr);
    rready     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_last  = 1'b0;
    resp_err   = 1'b0;
    case (state_q)
      StRdR: begin
        rready     = resp_ready;
        resp_valid = rvalid;
        resp_data  = rdata;
        resp_last  = rd_last;
        resp_err   = (rresp != RESP_OKAY) || (rid != RdId) || (rlast != cnt_at_len);
      end
      StWrB: begin
        bready     = resp_ready;
        resp_valid = bvalid;
        resp_last  = 1'b1;
        resp_err   = (bresp != RESP_OKAY) || (bid != WrId);
      end
      default: ;
    endcase

    araddr  = addr_q;
    arid    = RdId;
    arlen   = len_q;
    arsize  = size_q;
    arburst = BURST_INCR;
    arlock  = 2'b00;
    arcache = 4'h0;
    arprot  = 3'h0;

    awaddr  = addr_q;
    awid    = WrId;
    awlen   = 8'h00;
    awsize  = size_q;
    awburst = BURST_INCR;
    awlock  = 2'b00;
    awcache = 4'h0;
    awprot  = 3'h0;

    wid     = WrId;
    wdata   = wdata_q;
    wstrb   = wstrb_q;
    wlast   = 1'b1;
  end

  // Latched request fields and read beat counter
  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    if (req_hs) begin
      addr_d  = req_addr;
      len_d   = req_len;
      size_d  = req_size;
      wdata_d = req_wdata;
      wstrb_d = req_wstrb;
      cnt_d   = '0;
    end else if (r_hs) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Self-checking bench for axi4_master_bridge. The bench plays both the
// requester and the AXI slave; expected response beats are derived from the
// slave's own choices and queued, and a compare process checks every response
// handshake, every cycle's AXI request fields and the valid-stability rules.
module tb_axi4_master_bridge;
  import axi4_pkg::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic        req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = 0;
  logic [7:0]  req_len = 0;
  logic [2:0]  req_size = 0;
  logic [63:0] req_wdata = 0;
  logic [7:0]  req_wstrb = 0;
  logic        resp_valid, resp_ready = 0, resp_last, resp_err;
  logic [63:0] resp_data;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid, wid;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic [3:0]  arcache, awcache;
  logic        arvalid, arready = 0, awvalid, awready = 0, wvalid, wready = 0, wlast;
  logic [3:0]  rid = 0, bid = 0;
  logic [63:0] rdata = 0, wdata;
  logic [1:0]  rresp = 0, bresp = 0;
  logic        rlast = 0, rvalid = 0, rready, bvalid = 0, bready;

  axi4_master_bridge #(
    .ID_W(4), .ADDR_W(32), .DATA_W(64), .RD_ID(0), .WR_ID(1)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_addr = 0;
  logic [7:0]  exp_len = 0;
  logic [2:0]  exp_size = 0;
  logic [63:0] exp_wdata = 0;
  logic [7:0]  exp_wstrb = 0;
  bit          in_read = 0;
  logic [63:0] cap_data = 0;
  logic        cap_last = 0, cap_err = 0;
  logic [15:0] last_hist = 0;
  int          resp_cnt = 0;
  logic [63:0] force_data = 0;
  bit          force_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic rnd();
    return $urandom_range(0, 3) != 0;
  endfunction

  // Compare process
  logic p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_rst = 1;
  always @(negedge aclk) begin
    if (!areset) begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("resp_unexpected", "response handshake with nothing expected");
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("resp_beat", 128'({resp_data, resp_last, resp_err}), 128'({e.data, e.last, e.err}));
          cap_data  = resp_data;
          cap_last  = resp_last;
          cap_err   = resp_err;
          last_hist = {last_hist[14:0], resp_last};
          resp_cnt++;
        end
      end
      if (arvalid)
        chk("ar_fields",
            128'({araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid}),
            128'({exp_addr, exp_len, exp_size, 2'b01, 2'b00, 4'h0, 3'h0, 4'h0}));
      if (awvalid)
        chk("aw_fields",
            128'({awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awid}),
            128'({exp_addr, 8'h00, exp_size, 2'b01, 2'b00, 4'h0, 3'h0, 4'h1}));
      if (wvalid)
        chk("w_fields", 128'({wdata, wstrb, wlast, wid}),
            128'({exp_wdata, exp_wstrb, 1'b1, 4'h1}));
      if (in_read)
        chk("r_passthru", 128'({rready, resp_valid}), 128'({resp_ready, rvalid}));
      if (!p_rst) begin
        // Held while not accepted; single-beat channels drop once accepted.
        if (p_arv) chk("ar_stable", 128'(arvalid), 128'(!p_arr));
        if (p_awv) chk("aw_stable", 128'(awvalid), 128'(!p_awr));
        if (p_wv)  chk("w_stable", 128'(wvalid), 128'(!p_wr));
      end
    end
    p_arv <= arvalid; p_arr <= arready;
    p_awv <= awvalid; p_awr <= awready;
    p_wv  <= wvalid;  p_wr  <= wready;
    p_rst <= areset;
  end

  task automatic request(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [63:0] data,
                         input logic [7:0] strb, output bit ok);
    exp_addr = addr; exp_len = len; exp_size = size; exp_wdata = data; exp_wstrb = strb;
    req_valid = 1; req_write = wr; req_addr = addr; req_len = len; req_size = size;
    req_wdata = data; req_wstrb = strb;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge aclk);
      ok = req_ready;
      tick();
    end
    // Scramble the request bus so the bridge must rely on its latched copy.
    req_valid = 0; req_addr = $urandom; req_len = 8'($urandom); req_size = 3'($urandom);
    req_wdata = {$urandom, $urandom}; req_wstrb = 8'($urandom);
    if (!ok) fail_now("req_hs", "req_ready never rose");
  endtask

  task automatic idle_after();
    resp_ready = 0;
    @(negedge aclk);
    chk("req_ready_after_resp", 128'(req_ready), 128'(1'b1));
    tick();
  endtask

  task automatic reset_mid();
    rvalid = 1; rdata = {$urandom, $urandom}; rlast = 0; resp_ready = 1; areset = 1;
    @(negedge aclk);
    chk("req_ready_in_reset", 128'(req_ready), 128'(1'b0));
    tick();
    areset = 0; rvalid = 0; resp_ready = 0;
    @(negedge aclk);
    chk("post_reset_idle",
        128'({req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid}),
        128'(7'b1000000));
    tick();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int early_last, input int err_beat, input logic [1:0] err_code,
                         input int bad_id_beat, input int stall_beat, input bit abort);
    bit ok, hs, rl;
    beat_t e;
    int d;
    request(0, addr, len, size, 64'h0, 8'h0, ok);
    if (!ok) return;
    d = $urandom_range(0, 2);
    hs = 0;
    for (int i = 0; i < 20 && !hs; i++) begin
      arready = (i >= d); resp_ready = rnd();
      @(negedge aclk);
      if (i == 0) chk("arvalid_after_req", 128'(arvalid), 128'(1'b1));
      hs = arvalid && arready;
      tick();
    end
    arready = 0;
    if (!hs) begin fail_now("ar_hs", "AR handshake never happened"); return; end
    if (abort) begin reset_mid(); return; end
    in_read = 1;
    for (int k = 0; k <= int'(len); k++) begin
      repeat ($urandom_range(0, 2)) begin
        rvalid = 0; resp_ready = rnd(); tick();
      end
      rl     = (early_last >= 0) ? (k == early_last) : (k == int'(len));
      rvalid = 1;
      rlast  = rl;
      rid    = (k == bad_id_beat) ? 4'h7 : 4'h0;
      rresp  = (k == err_beat) ? err_code : RESP_OKAY;
      rdata  = (force_en && k == 0) ? force_data : {$urandom, $urandom};
      e.data = rdata;
      e.last = rl || (k == int'(len));
      e.err  = (rresp != RESP_OKAY) || (rid != 4'h0) || (rl != (k == int'(len)));
      exp_q.push_back(e);
      hs = 0;
      for (int i = 0; i < 40 && !hs; i++) begin
        resp_ready = (k == stall_beat && i < 2) ? 1'b0 : rnd();
        @(negedge aclk);
        hs = rvalid && rready;
        tick();
      end
      rvalid = 0; rlast = 0;
      if (!hs) begin
        fail_now("r_hs", "R beat never accepted");
        exp_q.delete(); in_read = 0;
        return;
      end
      if (e.last) break;
    end
    in_read = 0;
    idle_after();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                          input logic [63:0] data, input logic [7:0] strb,
                          input int aw_d, input int w_d, input logic [1:0] bresp_code,
                          input bit bad_bid);
    bit ok, aw_ok, w_ok, hs;
    beat_t e;
    request(1, addr, 8'h0, size, data, strb, ok);
    if (!ok) return;
    aw_ok = 0; w_ok = 0;
    for (int i = 0; i < 30 && !(aw_ok && w_ok); i++) begin
      awready = (i >= aw_d); wready = (i >= w_d); resp_ready = rnd();
      @(negedge aclk);
      if (i == 0) chk("aw_w_after_req", 128'({awvalid, wvalid}), 128'(2'b11));
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      tick();
    end
    awready = 0; wready = 0;
    if (!(aw_ok && w_ok)) begin fail_now("aw_w_hs", "AW/W handshakes incomplete"); return; end
    repeat ($urandom_range(0, 2)) begin resp_ready = rnd(); tick(); end
    bvalid = 1; bresp = bresp_code; bid = bad_bid ? 4'h9 : 4'h1;
    e.data = 64'h0; e.last = 1'b1;
    e.err  = (bresp != RESP_OKAY) || (bid != 4'h1);
    exp_q.push_back(e);
    hs = 0;
    for (int i = 0; i < 40 && !hs; i++) begin
      resp_ready = rnd();
      @(negedge aclk);
      hs = bvalid && bready;
      tick();
    end
    bvalid = 0;
    if (!hs) begin
      fail_now("b_hs", "B never accepted");
      exp_q.delete();
      return;
    end
    idle_after();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1;
    repeat (2) tick();
    @(negedge aclk);
    chk("reset_outputs",
        128'({req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_last,
              resp_err}), 128'(9'b0));
    tick();
    areset = 0;
    @(negedge aclk);
    chk("idle_after_reset",
        128'({req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_last,
              resp_err}), 128'(9'b100000000));
    tick();

    // Single read
    force_en = 1; force_data = 64'h1122334455667788; resp_cnt = 0;
    do_read(32'h8000_0000, 8'd0, 3'd3, -1, -1, RESP_OKAY, -1, -1, 0);
    force_en = 0;
    chk("t1_data", 128'(cap_data), 128'(64'h1122334455667788));
    chk("t1_last_err", 128'({cap_last, cap_err}), 128'(2'b10));
    chk("t1_count", 128'(resp_cnt), 128'(1));

    // Burst read with a resp_ready stall on beat 2
    resp_cnt = 0; last_hist = 0;
    do_read(32'h8000_0100, 8'd3, 3'd3, -1, -1, RESP_OKAY, -1, 2, 0);
    chk("t2_count", 128'(resp_cnt), 128'(4));
    chk("t2_last_only_final", 128'(last_hist), 128'(16'h0001));

    // Write, AW accepted two cycles before W
    resp_cnt = 0;
    do_write(32'h8000_0008, 3'd3, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 2, RESP_OKAY, 0);
    chk("t3_resp", 128'({cap_data, cap_last, cap_err}), 128'({64'h0, 1'b1, 1'b0}));
    chk("t3_count", 128'(resp_cnt), 128'(1));

    // Error responses
    do_read(32'h8000_0200, 8'd0, 3'd3, -1, 0, RESP_SLVERR, -1, -1, 0);
    chk("t4_rd_slverr", 128'({cap_last, cap_err}), 128'(2'b11));
    do_write(32'h8000_0210, 3'd2, 64'h55, 8'h01, 1, 0, RESP_DECERR, 0);
    chk("t4_wr_decerr", 128'({cap_last, cap_err}), 128'(2'b11));

    // rlast early on a two-beat burst
    resp_cnt = 0;
    do_read(32'h8000_0300, 8'd1, 3'd3, 0, -1, RESP_OKAY, -1, -1, 0);
    chk("t5_count", 128'(resp_cnt), 128'(1));
    chk("t5_last_err", 128'({cap_last, cap_err}), 128'(2'b11));

    // Reset while in the R phase, then a clean read
    do_read(32'h8000_0400, 8'd3, 3'd3, -1, -1, RESP_OKAY, -1, -1, 1);
    resp_cnt = 0;
    do_read(32'h8000_0500, 8'd2, 3'd3, -1, -1, RESP_OKAY, -1, -1, 0);
    chk("t6_count", 128'(resp_cnt), 128'(3));
    chk("t6_last_err", 128'({cap_last, cap_err}), 128'(2'b10));

    // Randomized mix
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [7:0] len;
        int early, eb, bib;
        len   = 8'($urandom_range(0, 7));
        early = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1;
        eb    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(len)) : -1;
        bib   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : -1;
        do_read($urandom, len, 3'($urandom_range(0, 3)), early, eb,
                2'($urandom_range(1, 3)), bib, -1, 0);
      end else begin
        do_write($urandom, 3'($urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY,
                 $urandom_range(0, 7) == 0);
      end
    end

    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
